mac_requant: RTL and testbench

Output stage directly downstream of the `mac` pipeline. It accepts a finished double-width accumulator value from `mac.f` and produces a single-width fixed-point result for the next layer.
- Rounds the value back to IL.FL format, with optional ReLU and saturation.
- Buffers results in a small FIFO with a valid/ready output handshake.
- Counts saturation events for debug.

---
 rtl/mac_requant.sv | 124 ++++++++++++
 tb/tb_mac_requant.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
// mac_requant: rounds a 2IL.2FL accumulator to IL.FL (optional ReLU, saturation) into a small output FIFO.
// Latency: 2 cycles from accept to out_valid; throughput 1/cycle.
// Backpressure: in_ready is a credit check on registered occupancy + stage-1 valid; a pop frees a credit one cycle later.
module mac_requant #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [2*(IL+FL)-1:0]     acc,
  input  logic                     relu,
  output logic                     in_ready,
  output logic [IL+FL-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clear_cnt,
  output logic [15:0]              sat_count
);

  localparam int W  = IL + FL;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [OW:0]          DEPTH_C = (OW+1)'(DEPTH);
  localparam logic [OW-1:0]        FULL_C  = OW'(DEPTH);
  localparam logic signed [2*W:0]  HALF    = {{(2*W+1-FL){1'b0}}, 1'b1, {(FL-1){1'b0}}};
  localparam logic signed [2*W:0]  QMAX    = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0]  QMIN    = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic                  accept;
  logic                  s1_vld;
  logic                  s1_neg;
  logic                  s1_relu;
  logic signed [2*W:0]   s1_r;

  logic signed [2*W:0]   q;
  logic [W-1:0]          res;
  logic                  res_sat;

  logic [W-1:0]          mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic                  push;
  logic                  pop;

  assign accept = in_valid && in_ready;

  // Stage 1: add the rounding half-LSB in 2W+1 bits so the sum cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_neg  <= 1'b0;
      s1_relu <= 1'b0;
      s1_r    <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_r    <= $signed({acc[2*W-1], acc}) + HALF;
        s1_neg  <= acc[2*W-1];
        s1_relu <= relu;
      end
    end
  end

  // Stage 2: arithmetic shift gives round-half-up, then ReLU / clamp.
  always_comb begin
    q       = s1_r >>> FL;
    res     = q[W-1:0];
    res_sat = 1'b0;
    if (s1_relu && s1_neg) begin
      res = '0;
    end else if (q > QMAX) begin
      res     = {1'b0, {(W-1){1'b1}}};
      res_sat = 1'b1;
    end else if (q < QMIN) begin
      res     = {1'b1, {(W-1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  assign push      = s1_vld;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign in_ready  = reset && (({1'b0, occ} + {{OW{1'b0}}, s1_vld}) < DEPTH_C);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (clear_cnt) begin
      sat_count <= '0;
    end else if (push && res_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  // The credit check guarantees a free slot whenever stage 1 holds a value.
  assert property (@(posedge clk) disable iff (!reset) !(push && (occ == FULL_C)));

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant at default parameters (W=20, accumulator 40 bits).
module tb_mac_requant;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [39:0] acc;
  logic        relu;
  logic        in_ready;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear_cnt;
  logic [15:0] sat_count;

  int n_chk = 0;
  int n_pass = 0;
  int nxt, lastv, expv, sh;

  mac_requant dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .acc       (acc),
    .relu      (relu),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clear_cnt (clear_cnt),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] acc_of(input int k);
    logic [39:0] t;
    t = 40'(k);
    return t << sh;
  endfunction

  function automatic logic [19:0] out_of(input int k);
    logic [19:0] t;
    t = 20'(k);
    return t << (sh - 16);
  endfunction

  // One cycle of streaming: offer value nxt (while nxt <= lastv), check any popped head.
  task automatic step();
    logic a, p;
    in_valid = (nxt <= lastv);
    acc      = acc_of(nxt);
    relu     = 1'b0;
    a = in_valid && in_ready;
    p = out_valid && out_ready;
    if (p) begin
      check("order", 40'(out_data), 40'(out_of(expv)));
      expv++;
    end
    tick();
    if (a) nxt++;
  endtask

  // Single isolated conversion with out_ready held high.
  task automatic conv(input string tag, input logic [39:0] a, input logic r, input logic [19:0] exp);
    in_valid  = 1'b1;
    acc       = a;
    relu      = r;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    relu     = 1'b0;
    check({tag, "_early"}, 40'(out_valid), 40'd0);
    tick();
    check({tag, "_vld"}, 40'(out_valid), 40'd1);
    check({tag, "_dat"}, 40'(out_data), 40'(exp));
    tick();
    check({tag, "_gone"}, 40'(out_valid), 40'd0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    acc       = '0;
    relu      = 1'b0;
    out_ready = 1'b0;
    clear_cnt = 1'b0;
    sh        = 32;

    tick();
    check("rst_in_ready", 40'(in_ready), 40'd0);
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_out_data", 40'(out_data), 40'd0);
    check("rst_sat_count", 40'(sat_count), 40'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 40'(in_ready), 40'd1);

    // Basic conversion and rounding
    conv("three", 40'h03_0000_0000, 1'b0, 20'h30000);
    check("three_sat", 40'(sat_count), 40'd0);
    conv("rnd_half", 40'h00_0000_8000, 1'b0, 20'h00001);
    conv("rnd_below", 40'h00_0000_7FFF, 1'b0, 20'h00000);
    conv("rnd_neg_half", 40'hFF_FFFF_8000, 1'b0, 20'h00000);
    conv("rnd_neg_1p5", 40'hFF_FFFE_8000, 1'b0, 20'hFFFFF);
    conv("relu_pos", 40'h03_0000_0000, 1'b1, 20'h30000);
    check("rnd_sat", 40'(sat_count), 40'd0);

    // Saturation, ReLU, clear
    conv("pos_sat", 40'h08_0000_0000, 1'b0, 20'h7FFFF);
    check("pos_sat_cnt", 40'(sat_count), 40'd1);
    conv("neg_sat", 40'hF7_0000_0000, 1'b0, 20'h80000);
    check("neg_sat_cnt", 40'(sat_count), 40'd2);
    conv("neg_min", 40'hF8_0000_0000, 1'b0, 20'h80000);
    check("neg_min_cnt", 40'(sat_count), 40'd2);
    conv("relu_neg", 40'hF7_0000_0000, 1'b1, 20'h00000);
    check("relu_neg_cnt", 40'(sat_count), 40'd2);
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    check("clear_cnt", 40'(sat_count), 40'd0);

    // Clear coinciding with a saturating write: clear wins
    conv("pre_clr", 40'h08_0000_0000, 1'b0, 20'h7FFFF);
    check("pre_clr_cnt", 40'(sat_count), 40'd1);
    in_valid = 1'b1;
    acc      = 40'h08_0000_0000;
    tick();
    in_valid  = 1'b0;
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    check("clr_wins", 40'(sat_count), 40'd0);
    tick();
    check("clr_wins_drained", 40'(out_valid), 40'd0);

    // Back-pressure: 6 offered with out_ready low, only 4 fit
    sh = 32; nxt = 1; lastv = 6; expv = 1;
    out_ready = 1'b0;
    repeat (6) step();
    check("bp_accepted", 40'(nxt - 1), 40'd4);
    check("bp_in_ready", 40'(in_ready), 40'd0);
    check("bp_head_vld", 40'(out_valid), 40'd1);
    check("bp_head_dat", 40'(out_data), 40'h10000);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && expv <= 6; i++) step();
    check("bp_all_out", 40'(expv), 40'd7);
    check("bp_all_in", 40'(nxt), 40'd7);
    check("bp_empty", 40'(out_valid), 40'd0);

    // Simultaneous push and pop with two entries buffered
    sh = 24; nxt = 10; lastv = 12; expv = 10;
    out_ready = 1'b0;
    repeat (3) step();
    check("sp_prefill", 40'(nxt), 40'd13);
    lastv     = 32;
    out_ready = 1'b1;
    repeat (20) step();
    check("sp_pops", 40'(expv), 40'd30);
    check("sp_accepts", 40'(nxt), 40'd33);
    for (int i = 0; i < 10 && expv <= 32; i++) step();
    check("sp_drained", 40'(expv), 40'd33);

    // Reset mid-operation: 3 buffered, 1 in stage 1, nonzero count
    conv("pre_rst", 40'h08_0000_0000, 1'b0, 20'h7FFFF);
    check("pre_rst_cnt", 40'(sat_count), 40'd1);
    sh = 24; nxt = 40; lastv = 43; expv = 40;
    out_ready = 1'b0;
    repeat (4) step();
    check("mr_filled", 40'(nxt), 40'd44);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mr_out_valid", 40'(out_valid), 40'd0);
    check("mr_out_data", 40'(out_data), 40'd0);
    check("mr_in_ready", 40'(in_ready), 40'd0);
    check("mr_sat_count", 40'(sat_count), 40'd0);
    #1;
    reset = 1'b1;
    #1;
    check("mr_rel_ready", 40'(in_ready), 40'd1);
    nxt = 50; lastv = 50; expv = 50;
    out_ready = 1'b1;
    step();
    check("mr_no_stale", 40'(out_valid), 40'd0);
    step();
    check("mr_new_vld", 40'(out_valid), 40'd1);
    check("mr_new_dat", 40'(out_data), 40'(out_of(50)));
    step();
    check("mr_popped", 40'(expv), 40'd51);
    check("mr_empty", 40'(out_valid), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
